key_search_ctrl: RTL and testbench
==================================

// Module: key_search_ctrl
// PURPOSE
// Brute-force key-search controller sitting directly upstream of the arcfour core.
// Drives the 24-bit switch_key and the start handshake, and watches finished/success.
// Steps through a key range until the core reports a successful decrypt or the range is exhausted.
// Exposes the current or winning key for the LEDR/HEX display logic in the top level.
// PARAMETERS
// KEY_WIDTH  22        significant key bits; the upper 24-KEY_WIDTH bits of every key are driven 0
// KEY_FIRST  0         first key tried after go
// KEY_LAST   2**22-1   last key tried; must be >= KEY_FIRST and < 2**KEY_WIDTH
// KEY_STEP   1         key increment; >1 lets N controllers interleave one range
// PORTS
// clk            in   1      system clock (CLOCK_50)
// reset          in   1      asynchronous, active-low reset
// go             in   1      start/restart search; one-cycle pulse, already edge-detected
// abort          in   1      stop the search and return to IDLE
// core_start     out  1      one-cycle start pulse to arcfour
// core_key       out  24     switch_key to arcfour, packed as {byte2,byte1,byte0}
// core_finished  in   1      arcfour_finished level
// core_success   in   1      arcfour success; valid only while core_finished=1
// busy           out  1      search in progress
// found          out  1      sticky: key found
// exhausted      out  1      sticky: range done without success
// result_key     out  24     winning key when found=1, otherwise equal to core_key
// keys_tried     out  KEY_WIDTH+1  number of completed core runs
// BEHAVIOUR
// - Reset (reset=0, async): state=IDLE, core_key=KEY_FIRST, result_key=KEY_FIRST; all other outputs 0.
// - FSM states: IDLE, LAUNCH, WAIT_DROP, WAIT_DONE, FOUND, EXHAUSTED.
// - IDLE/FOUND/EXHAUSTED + go: clear found, exhausted and keys_tried; set core_key=KEY_FIRST; go to LAUNCH.
// - LAUNCH: core_start=1 for exactly this cycle; go to WAIT_DROP.
// - WAIT_DROP: wait until core_finished=0, which rejects a stale finished from the previous run.
//   Then go to WAIT_DONE.
// - WAIT_DONE: wait until core_finished=1, then on that cycle increment keys_tried:
//   - core_success=1 -> FOUND, latch result_key=core_key, found=1.
//   - otherwise, if core_key+KEY_STEP > KEY_LAST (computed 25-bit, no wrap) -> EXHAUSTED, exhausted=1.
//   - otherwise core_key += KEY_STEP and go to LAUNCH.
// - busy=1 in LAUNCH, WAIT_DROP and WAIT_DONE only.
// - core_key holds stable from LAUNCH until WAIT_DONE exits.
// - Per-key overhead beyond core latency: 3 cycles (LAUNCH, min 1 WAIT_DROP, WAIT_DONE).
// - go while busy is ignored.
// - abort in any state -> IDLE next cycle. Clears busy and found/exhausted; keys_tried and core_key are held.
// - abort and go in the same cycle: abort wins.
// - abort in the same cycle as core_finished=1 and core_success=1: abort wins, found stays 0.
// - KEY_FIRST=KEY_LAST: exactly one run, then FOUND or EXHAUSTED.
// - keys_tried saturates at all-ones and never wraps.
// - Reset mid-search: async return to reset values; no core_start is issued until the next go.
// STRUCTURE
// - Shared package rc4_pkg holds:
//   - typedef key_t = logic [2:0][7:0];
//   - KEY_BYTES=3;
//   - enum search_state_t {IDLE,LAUNCH,WAIT_DROP,WAIT_DONE,FOUND,EXHAUSTED}.
// - Sub-module key_stepper holds the core_key register with load/step/last-detect.
//   It is KEY_FIRST/KEY_LAST/KEY_STEP parameterised with a 25-bit overflow-safe compare.
// - The FSM and counters stay in key_search_ctrl.
// TESTING
// Bench uses KEY_WIDTH=4, KEY_LAST=15, and a mock core with 5-cycle latency that asserts success for one chosen key.
// - Success key 6, go -> core_key steps 0..6; found=1, result_key=24'h000006, keys_tried=7, busy=0.
// - No success key -> 16 runs; exhausted=1, keys_tried=16, and core_start never fires with key>15.
// - KEY_FIRST=1, KEY_STEP=2, success key 6 -> only odd keys tried; exhausted=1 after key 15, keys_tried=8.
// - abort in the cycle after core_start on key 3 -> IDLE next cycle, busy=0.
//   Then go restarts at key 0 with keys_tried=0.
// - Mock holds finished=1 across a new start (stale finished) -> no double count; the next key is issued only after finished falls and rises.
// - reset=0 mid WAIT_DONE -> all outputs at reset values at once; then go while found=1 restarts cleanly.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types for the arcfour key-search slice: key packing and the search FSM encoding.
package rc4_pkg;

  localparam int KEY_BYTES = 3;

  // Key bytes are packed {byte2,byte1,byte0}, matching the core's switch_key.
  typedef logic [KEY_BYTES-1:0][7:0] key_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_DROP = 3'd2,
    WAIT_DONE = 3'd3,
    FOUND     = 3'd4,
    EXHAUSTED = 3'd5
  } search_state_t;

endpackage

// File: rtl/key_stepper.sv
// Holds the key presented to the arcfour core; loads KEY_FIRST, advances by KEY_STEP,
// and flags when the next step would pass KEY_LAST.
module key_stepper
  import rc4_pkg::*;
#(
  parameter int KEY_WIDTH = 22,
  parameter int KEY_FIRST = 0,
  parameter int KEY_LAST  = 2**22-1,
  parameter int KEY_STEP  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  output logic [23:0] key,
  output logic        last
);

  localparam logic [23:0] KEY_MASK = 24'((64'd1 << KEY_WIDTH) - 64'd1);
  localparam logic [23:0] FIRST24  = 24'(KEY_FIRST);
  localparam logic [24:0] LAST25   = 25'(KEY_LAST);
  localparam logic [24:0] STEP25   = 25'(KEY_STEP);

  key_t        key_q;
  logic [24:0] next_key;

  // One spare bit so a step past 2**24-1 compares as "beyond last" instead of wrapping.
  assign next_key = {1'b0, key_q} + STEP25;
  assign last     = (next_key > LAST25);
  assign key      = key_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_q <= FIRST24 & KEY_MASK;
    end else if (load) begin
      key_q <= FIRST24 & KEY_MASK;
    end else if (step && !last) begin
      key_q <= next_key[23:0] & KEY_MASK;
    end
  end

endmodule

// File: rtl/key_search_ctrl.sv
// Brute-force key-search controller: launches the arcfour core once per key until it
// reports success or the key range is exhausted.
module key_search_ctrl
  import rc4_pkg::*;
#(
  parameter int KEY_WIDTH = 22,
  parameter int KEY_FIRST = 0,
  parameter int KEY_LAST  = 2**22-1,
  parameter int KEY_STEP  = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic               abort,
  output logic               core_start,
  output logic [23:0]        core_key,
  input  logic               core_finished,
  input  logic               core_success,
  output logic               busy,
  output logic               found,
  output logic               exhausted,
  output logic [23:0]        result_key,
  output logic [KEY_WIDTH:0] keys_tried,
  output logic [2:0]         dbg_state
);

  // Core handshake: core_start is a single-cycle request; core_finished is a level that
  // must be seen low then high before a run counts, and core_success is only sampled
  // on the cycle core_finished is observed high in WAIT_DONE.

  localparam logic [2:0] S_IDLE      = IDLE;
  localparam logic [2:0] S_LAUNCH    = LAUNCH;
  localparam logic [2:0] S_WAIT_DROP = WAIT_DROP;
  localparam logic [2:0] S_WAIT_DONE = WAIT_DONE;
  localparam logic [2:0] S_FOUND     = FOUND;
  localparam logic [2:0] S_EXHAUSTED = EXHAUSTED;

  localparam logic [KEY_WIDTH:0] TRIED_ONE = {{KEY_WIDTH{1'b0}}, 1'b1};

  logic [2:0] state;
  logic       key_last;
  logic       at_rest;
  logic       done_cycle;
  logic       load_key;
  logic       step_key;
  key_t       win_key;

  assign at_rest    = (state == S_IDLE) || (state == S_FOUND) || (state == S_EXHAUSTED);
  assign done_cycle = !abort && (state == S_WAIT_DONE) && core_finished;
  assign load_key   = !abort && go && at_rest;
  assign step_key   = done_cycle && !core_success;

  key_stepper #(
    .KEY_WIDTH (KEY_WIDTH),
    .KEY_FIRST (KEY_FIRST),
    .KEY_LAST  (KEY_LAST),
    .KEY_STEP  (KEY_STEP)
  ) u_stepper (
    .clk   (clk),
    .reset (reset),
    .load  (load_key),
    .step  (step_key),
    .key   (core_key),
    .last  (key_last)
  );

  assign core_start = (state == S_LAUNCH);
  assign busy       = (state == S_LAUNCH) || (state == S_WAIT_DROP) || (state == S_WAIT_DONE);
  assign result_key = found ? win_key : core_key;
  assign dbg_state  = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      found      <= 1'b0;
      exhausted  <= 1'b0;
      keys_tried <= '0;
      win_key    <= '0;
    end else if (abort) begin
      state     <= S_IDLE;
      found     <= 1'b0;
      exhausted <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_FOUND, S_EXHAUSTED: begin
          if (go) begin
            found      <= 1'b0;
            exhausted  <= 1'b0;
            keys_tried <= '0;
            state      <= S_LAUNCH;
          end
        end
        S_LAUNCH:    state <= S_WAIT_DROP;
        S_WAIT_DROP: if (!core_finished) state <= S_WAIT_DONE;
        S_WAIT_DONE: begin
          if (core_finished) begin
            if (keys_tried != '1) keys_tried <= keys_tried + TRIED_ONE;
            if (core_success) begin
              state   <= S_FOUND;
              found   <= 1'b1;
              win_key <= core_key;
            end else if (key_last) begin
              state     <= S_EXHAUSTED;
              exhausted <= 1'b1;
            end else begin
              state <= S_LAUNCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_search_ctrl.sv
// Bench for key_search_ctrl: two instances (step 1 from 0, step 2 from 1) each driven by a
// mock arcfour core, checked against a key-range model and an expected start-key queue.
module tb_key_search_ctrl;
  import rc4_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        go_a = 1'b0, abort_a = 1'b0;
  logic        start_a, fin_a, suc_a, busy_a, found_a, exh_a;
  logic [23:0] key_a, res_a;
  logic [4:0]  tried_a;
  logic [2:0]  st_a;

  logic        go_b = 1'b0, abort_b = 1'b0;
  logic        start_b, fin_b, suc_b, busy_b, found_b, exh_b;
  logic [23:0] key_b, res_b;
  logic [4:0]  tried_b;
  logic [2:0]  st_b;

  key_search_ctrl #(.KEY_WIDTH(4), .KEY_FIRST(0), .KEY_LAST(15), .KEY_STEP(1)) dut_a (
    .clk(clk), .reset(reset), .go(go_a), .abort(abort_a), .core_start(start_a),
    .core_key(key_a), .core_finished(fin_a), .core_success(suc_a), .busy(busy_a),
    .found(found_a), .exhausted(exh_a), .result_key(res_a), .keys_tried(tried_a),
    .dbg_state(st_a));

  key_search_ctrl #(.KEY_WIDTH(4), .KEY_FIRST(1), .KEY_LAST(15), .KEY_STEP(2)) dut_b (
    .clk(clk), .reset(reset), .go(go_b), .abort(abort_b), .core_start(start_b),
    .core_key(key_b), .core_finished(fin_b), .core_success(suc_b), .busy(busy_b),
    .found(found_b), .exhausted(exh_b), .result_key(res_b), .keys_tried(tried_b),
    .dbg_state(st_b));

  int succ_a = 99, stale_a = 0, succ_b = 99;
  int n_checks = 0, n_pass = 0;
  logic [31:0] exp_q[$];

  // Mock cores: 5-cycle latency after start; optional stale finished held for a few cycles.
  int cnt_a, hold_a, cnt_b;
  logic [23:0] lat_a, lat_b;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fin_a <= 1'b0; suc_a <= 1'b0; cnt_a <= 0; hold_a <= 0; lat_a <= '0;
    end else if (start_a) begin
      cnt_a <= 5; hold_a <= stale_a; suc_a <= 1'b0; lat_a <= key_a;
      if (stale_a == 0) fin_a <= 1'b0;
    end else if (hold_a > 0) begin
      hold_a <= hold_a - 1;
      if (hold_a == 1) fin_a <= 1'b0;
    end else if (cnt_a > 0) begin
      cnt_a <= cnt_a - 1;
      if (cnt_a == 1) begin
        fin_a <= 1'b1;
        suc_a <= (int'(lat_a) == succ_a);
      end
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fin_b <= 1'b0; suc_b <= 1'b0; cnt_b <= 0; lat_b <= '0;
    end else if (start_b) begin
      cnt_b <= 5; suc_b <= 1'b0; fin_b <= 1'b0; lat_b <= key_b;
    end else if (cnt_b > 0) begin
      cnt_b <= cnt_b - 1;
      if (cnt_b == 1) begin
        fin_b <= 1'b1;
        suc_b <= (int'(lat_b) == succ_b);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
  endtask

  // scoreboard: every core_start must carry the next key the model predicted
  task automatic mon_start(input logic [23:0] k);
    logic had_exp;
    check("start_key_in_range", {31'd0, k <= 24'd15}, 32'd1);
    had_exp = (exp_q.size() != 0);
    check("start_expected", {31'd0, had_exp}, 32'd1);
    if (had_exp) check("start_key", {8'd0, k}, exp_q.pop_front());
  endtask

  always @(negedge clk) begin
    if (start_a) mon_start(key_a);
    if (start_b) mon_start(key_b);
  end

  // Reference: walk the range by the step, stop at the success key if it is in range.
  task automatic model(input int first, input int step, input int last, input int succ,
                       output int n, output bit f, output int rk);
    n = 0; f = 1'b0; rk = first;
    exp_q.delete();
    for (int k = first; k <= last; k += step) begin
      exp_q.push_back(k);
      n++;
      rk = k;
      if (k == succ) begin
        f = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_go(input bit sel);
    @(negedge clk);
    if (sel) go_b = 1'b1; else go_a = 1'b1;
    @(negedge clk);
    go_a = 1'b0; go_b = 1'b0;
  endtask

  task automatic wait_end(input bit sel, input int budget);
    int i = 0;
    while (!(sel ? (found_b || exh_b) : (found_a || exh_a)) && i < budget) begin
      @(negedge clk);
      i++;
    end
    check("wait_timeout", {31'd0, i >= budget}, 32'd0);
  endtask

  // Full run on instance sel; busy_go pulses go mid-run to confirm it is ignored.
  task automatic run(input bit sel, input int succ, input int stale, input bit busy_go);
    int n, rk; bit f;
    if (sel) succ_b = succ; else begin succ_a = succ; stale_a = stale; end
    if (sel) model(1, 2, 15, succ, n, f, rk); else model(0, 1, 15, succ, n, f, rk);
    pulse_go(sel);
    check("go_clears_tried", sel ? tried_b : tried_a, 32'd0);
    check("go_clears_found", sel ? found_b : found_a, 32'd0);
    check("go_clears_exh", sel ? exh_b : exh_a, 32'd0);
    check("go_first_key", sel ? key_b : key_a, sel ? 32'd1 : 32'd0);
    check("go_busy", sel ? busy_b : busy_a, 32'd1);
    if (busy_go) begin
      repeat (12) @(negedge clk);
      pulse_go(sel);
    end
    wait_end(sel, 3000);
    check("found", sel ? found_b : found_a, {31'd0, f});
    check("exhausted", sel ? exh_b : exh_a, {31'd0, !f});
    check("keys_tried", sel ? tried_b : tried_a, n);
    check("result_key", sel ? res_b : res_a, rk);
    check("busy_after", sel ? busy_b : busy_a, 32'd0);
    check("end_state", sel ? st_b : st_a, f ? FOUND : EXHAUSTED);
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_values();
    check("rst_busy_a", busy_a, 0);   check("rst_found_a", found_a, 0);
    check("rst_exh_a", exh_a, 0);     check("rst_start_a", start_a, 0);
    check("rst_key_a", key_a, 0);     check("rst_res_a", res_a, 0);
    check("rst_tried_a", tried_a, 0); check("rst_state_a", st_a, IDLE);
    check("rst_key_b", key_b, 1);     check("rst_res_b", res_b, 1);
    check("rst_busy_b", busy_b, 0);   check("rst_tried_b", tried_b, 0);
  endtask

  initial begin
    int i;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values();
    reset = 1'b1;
    repeat (2) @(negedge clk);

    run(1'b0, 6, 0, 1'b0);
    run(1'b0, 99, 0, 1'b0);
    run(1'b1, 6, 0, 1'b0);
    run(1'b0, 4, 3, 1'b0);
    run(1'b0, 5, 0, 1'b1);
    repeat (4) begin
      run(1'b0, $urandom_range(0, 19), $urandom_range(0, 2), 1'b0);
      run(1'b1, $urandom_range(0, 19), 0, 1'b0);
    end
    stale_a = 0;

    // abort in the cycle after core_start on key 3
    succ_a = 99;
    begin int n, rk; bit f; model(0, 1, 15, 99, n, f, rk); end
    pulse_go(1'b0);
    i = 0;
    while (!(start_a && key_a == 24'd3) && i < 500) begin @(negedge clk); i++; end
    check("abort_wait_timeout", {31'd0, i >= 500}, 32'd0);
    @(negedge clk); abort_a = 1'b1;
    @(negedge clk); abort_a = 1'b0;
    exp_q.delete();
    check("abort_state", st_a, IDLE);
    check("abort_busy", busy_a, 0);
    check("abort_tried_held", tried_a, 3);
    check("abort_key_held", key_a, 3);
    run(1'b0, 2, 0, 1'b0);

    // abort and go together from FOUND: abort wins
    @(negedge clk); go_a = 1'b1; abort_a = 1'b1;
    @(negedge clk); go_a = 1'b0; abort_a = 1'b0;
    check("abort_go_state", st_a, IDLE);
    check("abort_go_found", found_a, 0);
    repeat (3) @(negedge clk);
    check("abort_go_busy", busy_a, 0);

    // abort on the success cycle: found must stay 0
    succ_a = 2;
    begin int n, rk; bit f; model(0, 1, 15, 2, n, f, rk); end
    pulse_go(1'b0);
    i = 0;
    while (!(fin_a && st_a == WAIT_DONE && key_a == 24'd2) && i < 500) begin @(negedge clk); i++; end
    check("abort_succ_timeout", {31'd0, i >= 500}, 32'd0);
    abort_a = 1'b1;
    @(negedge clk); abort_a = 1'b0;
    check("abort_succ_found", found_a, 0);
    check("abort_succ_state", st_a, IDLE);
    check("abort_succ_tried", tried_a, 2);
    exp_q.delete();

    // reset mid WAIT_DONE
    succ_a = 6;
    begin int n, rk; bit f; model(0, 1, 15, 6, n, f, rk); end
    pulse_go(1'b0);
    i = 0;
    while (!(st_a == WAIT_DONE && key_a == 24'd2) && i < 500) begin @(negedge clk); i++; end
    check("rst_mid_timeout", {31'd0, i >= 500}, 32'd0);
    exp_q.delete();
    reset = 1'b0;
    #1;
    check_reset_values();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("no_start_after_reset", st_a, IDLE);
    run(1'b0, 6, 0, 1'b0);
    run(1'b0, 11, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
